// File: rtl/store_seq_pkg.sv
// store_seq_pkg: store sequencer FSM states, store-type codes, counter width, alignment helper
package store_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_WRITE, S_FIN} state_t;
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SW = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;
  localparam logic [1:0] ST_SH = 2'b11;
  localparam int CNT_W = 3;
  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
    return (t == ST_SW && a != 2'b00) || (t == ST_SH && a[0]);
  endfunction
endpackage

// File: rtl/rd_lat_counter.sv
// rd_lat_counter: loadable down-counter for the READ wait (clk, reset, i_load, i_dec, i_load_val -> o_zero)
module rd_lat_counter
  import store_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/store_seq_ctrl.sv
// store_seq_ctrl: multicycle store sequencer (start/store_type/addr_in in; mem_addr/mem_wr/mdr_load/ss_control/busy/done/store_err out); STORE_ALIGN_CHECK_EN rejects misaligned sw/sh
module store_seq_ctrl
  import store_seq_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr_in,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic        mdr_load,
  output logic [1:0]  ss_control,
  output logic        busy,
  output logic        done,
  output logic        store_err
);
  localparam logic [CNT_W-1:0] LD_VAL = CNT_W'(MEM_RD_LAT - 1);
  state_t      r_state, w_next;
  logic [1:0]  r_type;
  logic [31:0] r_addr;
  logic        r_err;
  logic        w_accept, w_bad, w_zero;
  assign w_accept = r_state == S_IDLE && start;
`ifdef STORE_ALIGN_CHECK_EN
  assign w_bad = store_type == ST_NONE || misaligned(store_type, addr_in[1:0]);
`else
  assign w_bad = store_type == ST_NONE;
`endif
  rd_lat_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_dec     (r_state == S_READ),
    .i_load_val(LD_VAL),
    .o_zero    (w_zero)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_type  <= ST_NONE;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_type <= store_type;
        r_addr <= addr_in;
        r_err  <= w_bad;
      end
    end
  always_comb begin
    w_next     = r_state;
    mem_wr     = 1'b0;
    mdr_load   = 1'b0;
    ss_control = ST_NONE;
    busy       = r_state != S_IDLE;
    done       = 1'b0;
    store_err  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = w_bad ? S_FIN : store_type == ST_SW ? S_WRITE : S_READ;
      S_READ:  if (w_zero) w_next = S_LOAD;
      S_LOAD: begin
        mdr_load = 1'b1;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        mem_wr     = 1'b1;
        ss_control = r_type;
        w_next     = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        store_err = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  assign mem_addr = r_addr;
endmodule

// File: doc/store_seq_ctrl.md
STORE_SEQ_CTRL -- requirements
Module: store_seq_ctrl

Interface
REQ-001 SHALL have parameter: MEM_RD_LAT, 1, memory read latency in cycles (1..7) from address valid to data valid on MDR input.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle store request; sampled only in IDLE.
REQ-005 SHALL have port: store_type  input  2  01 sw, 11 sh, 10 sb, 00 invalid; sampled with start.
REQ-006 SHALL have port: addr_in  input  32  byte address (ALUOut); sampled with start.
REQ-007 SHALL have port: mem_addr  output  32  registered address to memory.
REQ-008 SHALL have port: mem_wr  output  1  memory write strobe.
REQ-009 SHALL have port: mdr_load  output  1  MDR capture enable.
REQ-010 SHALL have port: ss_control  output  2  select for the store-size merge unit.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: store_err  output  1  one-cycle error pulse, coincident with done.

Function
REQ-014 SHALL implement states IDLE, READ, LOAD, WRITE, FIN.
REQ-015 IDLE with start=1: latch store_type and addr_in; sw -> WRITE; sh/sb -> READ; 00 -> FIN with store_err.
REQ-016 start while busy SHALL be ignored; the request is not queued.
REQ-017 READ: mem_wr=0, mem_addr=latched address; stays MEM_RD_LAT cycles (down-counter), then -> LOAD.
REQ-018 LOAD: mdr_load=1 for exactly one cycle, then -> WRITE.
REQ-019 WRITE: mem_wr=1 and ss_control=latched store_type for exactly one cycle, then -> FIN.
REQ-020 FIN: done=1 for one cycle, then -> IDLE; start in FIN is ignored.
REQ-021 ss_control SHALL be 00 in all states except WRITE; mem_wr is never asserted outside WRITE.
REQ-022 Latency start->done: sw 2 cycles; sh/sb MEM_RD_LAT+3 cycles; invalid type 1 cycle.
REQ-023 mem_addr SHALL remain stable from READ entry through WRITE exit.
REQ-024 Back-to-back: a start in the cycle after done SHALL be accepted.

Reset
REQ-025 reset SHALL force IDLE and, on the next edge, mem_addr=0, mem_wr=0, mdr_load=0, ss_control=00, busy=0, done=0, store_err=0, counter=0.
REQ-026 reset mid-operation SHALL abort without asserting mem_wr or done; reset overrides start in the same cycle.

Configuration
REQ-027 With STORE_ALIGN_CHECK_EN defined: sw with addr_in[1:0]!=0 or sh with addr_in[0]!=0 SHALL go IDLE->FIN with store_err=1 and no memory access.
REQ-028 Without STORE_ALIGN_CHECK_EN: no alignment check; misaligned stores execute normally and store_err flags only invalid type.

Structure
REQ-029 Package store_seq_pkg SHALL hold the state enum and the store-type constants (ST_SW=01, ST_SH=11, ST_SB=10, ST_NONE=00).
REQ-030 Sub-module rd_lat_counter (load MEM_RD_LAT, decrement, zero flag) SHALL implement the READ wait.

Verification
REQ-031 sw, addr 0x0000_0010, MEM_RD_LAT=1: WRITE at cycle 1 with ss_control=01, done at cycle 2, no mdr_load.
REQ-032 sb, addr 0x0000_0013, MEM_RD_LAT=2: READ 2 cycles, mdr_load at cycle 3, mem_wr with ss_control=10 at cycle 4, done at cycle 5.
REQ-033 store_type=00: done and store_err at cycle 1; mem_wr never asserted.
REQ-034 sh started, reset asserted in READ: all outputs 0 after next edge, no mem_wr, no done.
REQ-035 start held high through sw: exactly one WRITE; second sw accepted in the cycle after done.
REQ-036 With STORE_ALIGN_CHECK_EN, sw to 0x0000_0002: store_err and done at cycle 1, no access; without it, normal sw timing.
